// File: rtl/hrm_pkg.sv
// ============================================================================
// Module      : hrm_pkg
// Description : Shared definitions for the HRM CPU program loader: loader
//               state encoding and the ASCII control characters it parses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hrm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI     = 3'd1,
        LO     = 3'd2,
        CHK_HI = 3'd3,
        CHK_LO = 3'd4
    } prog_loader_state_t;

    localparam logic [7:0] CH_L   = 8'h4C;
    localparam logic [7:0] CH_G   = 8'h47;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_TAB = 8'h09;

    // Whitespace that may separate byte pairs in the load stream
    function automatic logic is_space(input logic [7:0] ch);
        return (ch == CH_SP) || (ch == CH_CR) || (ch == CH_LF) || (ch == CH_TAB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_nibble.sv
// ============================================================================
// Module      : hex_nibble
// Description : Combinational ASCII-to-nibble decoder. Accepts 0-9, A-F and
//               a-f; valid is low for any other character.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_nibble (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       valid
);

    // Decode the character; letters share low-nibble layout so add 9
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        if ((ch >= 8'h30) && (ch <= 8'h39)) begin
            nibble = ch[3:0];
            valid  = 1'b1;
        end else if (((ch >= 8'h41) && (ch <= 8'h46)) ||
                     ((ch >= 8'h61) && (ch <= 8'h66))) begin
            nibble = ch[3:0] + 4'd9;
            valid  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Serial program loader for the HRM CPU. Parses an ASCII-hex
//               stream ("L" start, hex byte pairs, "G" end) and writes the
//               bytes sequentially into program memory while holding the
//               CPU in reset. Define PROG_LOADER_CHKSUM_EN to require a
//               two-digit mod-256 checksum after "G".
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import hrm_pkg::*;
#(
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            prog_din,
    output logic [addr_width-1:0] prog_addr,
    output logic                  prog_we,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [addr_width:0]   byte_count
);

    // Count value meaning the memory is completely filled
    localparam logic [addr_width:0]   COUNT_FULL = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0]   COUNT_ONE  = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] ADDR_ONE   = addr_width'(1);

    prog_loader_state_t state;
    logic [3:0]         hi_nib;
    logic [3:0]         nibble;
    logic               hex_valid;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0]         chksum;
    logic [3:0]         chk_hi;
`endif

    hex_nibble u_hex_nibble (
        .ch     (rx_data),
        .nibble (nibble),
        .valid  (hex_valid)
    );

    // Loader FSM with registered memory-port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hi_nib     <= 4'h0;
            prog_din   <= 8'h00;
            prog_addr  <= '0;
            prog_we    <= 1'b0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            chksum     <= 8'h00;
            chk_hi     <= 4'h0;
`endif
        end else begin
            prog_we   <= 1'b0;
            load_done <= 1'b0;

            // Address advances the cycle after the strobe; it parks on the
            // last location once the memory is full rather than wrapping.
            if (prog_we && (byte_count != COUNT_FULL)) begin
                prog_addr <= prog_addr + ADDR_ONE;
            end

            if (rx_valid) begin
                if ((rx_data == CH_L) &&
                    ((state == IDLE) || (state == HI) || (state == LO))) begin
                    // Start (or restart) a load; overrides any pending increment
                    prog_addr  <= '0;
                    byte_count <= '0;
                    load_err   <= 1'b0;
                    cpu_hold   <= 1'b1;
                    state      <= HI;
`ifdef PROG_LOADER_CHKSUM_EN
                    chksum     <= 8'h00;
`endif
                end else begin
                    case (state)
                        HI: begin
                            if (hex_valid) begin
                                hi_nib <= nibble;
                                state  <= LO;
                            end else if (rx_data == CH_G) begin
`ifdef PROG_LOADER_CHKSUM_EN
                                state     <= CHK_HI;
`else
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                                state     <= IDLE;
`endif
                            end else if (!is_space(rx_data)) begin
                                load_err <= 1'b1;
                                cpu_hold <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                        LO: begin
                            if (hex_valid && (byte_count != COUNT_FULL)) begin
                                prog_din   <= {hi_nib, nibble};
                                prog_we    <= 1'b1;
                                byte_count <= byte_count + COUNT_ONE;
                                state      <= HI;
`ifdef PROG_LOADER_CHKSUM_EN
                                chksum     <= chksum + {hi_nib, nibble};
`endif
                            end else begin
                                // Bad character or memory already full
                                load_err <= 1'b1;
                                cpu_hold <= 1'b0;
                                state    <= IDLE;
                            end
                        end
`ifdef PROG_LOADER_CHKSUM_EN
                        CHK_HI: begin
                            if (hex_valid) begin
                                chk_hi <= nibble;
                                state  <= CHK_LO;
                            end else begin
                                load_err <= 1'b1;
                                cpu_hold <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                        CHK_LO: begin
                            if (hex_valid && ({chk_hi, nibble} == chksum)) begin
                                load_done <= 1'b1;
                            end else begin
                                load_err  <= 1'b1;
                            end
                            cpu_hold <= 1'b0;
                            state    <= IDLE;
                        end
`endif
                        default: begin
                            // IDLE ignores everything except the start character
                            state <= state;
                        end
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Scoreboard bench for prog_loader. Expected writes and
//               done/error events are queued as stimulus is issued; monitors
//               pop and compare when the DUTs present them. A second
//               instance with addr_width=2 exercises the full-memory case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prog_loader;

    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       drv_valid;
    int         sel;
    logic       rx_valid_a;
    logic       rx_valid_b;

    assign rx_valid_a = drv_valid && (sel == 0);
    assign rx_valid_b = drv_valid && (sel == 1);

    logic [7:0] din_a, din_b;
    logic [7:0] addr_a;
    logic [1:0] addr_b;
    logic       we_a, we_b, hold_a, hold_b, done_a, done_b, err_a, err_b;
    logic [8:0] cnt_a;
    logic [2:0] cnt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int last_we_cyc   = -1;
    int last_done_cyc = -1;

    logic [31:0] wq_a[$];
    logic [31:0] wq_b[$];
    int          eq_a[$];
    int          eq_b[$];
    logic        err_a_q = 1'b0;
    logic        err_b_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader #(.addr_width(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_a),
        .prog_din(din_a), .prog_addr(addr_a), .prog_we(we_a),
        .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a),
        .byte_count(cnt_a)
    );

    prog_loader #(.addr_width(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_b),
        .prog_din(din_b), .prog_addr(addr_b), .prog_we(we_b),
        .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b),
        .byte_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_event(input string name, input int kind, ref int q[$]);
        if (q.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: got event %0d expected none", name, kind);
        end else begin
            check(name, kind, q.pop_front());
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_a) begin
                last_we_cyc = cyc;
                if (wq_a.size() == 0) begin
                    total_cnt++;
                    $display("FAIL write_a: got %0h@%0h expected no write", din_a, addr_a);
                end else begin
                    check("write_a", {16'h0, addr_a, din_a}, wq_a.pop_front());
                end
            end
            if (done_a) begin
                last_done_cyc = cyc;
                check_event("done_a", EV_DONE, eq_a);
                check("hold_at_done_a", {31'h0, hold_a}, 32'h0);
            end
            if (err_a && !err_a_q) begin
                check_event("err_a", EV_ERR, eq_a);
                check("hold_at_err_a", {31'h0, hold_a}, 32'h0);
            end
        end
        err_a_q = err_a;
    end

    // Monitor for the 2-bit-address instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_b) begin
                if (wq_b.size() == 0) begin
                    total_cnt++;
                    $display("FAIL write_b: got %0h@%0h expected no write", din_b, addr_b);
                end else begin
                    check("write_b", {22'h0, addr_b, din_b}, wq_b.pop_front());
                end
            end
            if (done_b) check_event("done_b", EV_DONE, eq_b);
            if (err_b && !err_b_q) begin
                check_event("err_b", EV_ERR, eq_b);
                check("hold_at_err_b", {31'h0, hold_b}, 32'h0);
            end
        end
        err_b_q = err_b;
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic push_wa(input logic [7:0] a, input logic [7:0] d);
        wq_a.push_back({16'h0, a, d});
    endtask

    task automatic push_wb(input logic [1:0] a, input logic [7:0] d);
        wq_b.push_back({22'h0, a, d});
    endtask

    task automatic send(input int s, input logic [7:0] c);
        @(posedge clk); #1;
        sel = s; rx_data = c; drv_valid = 1'b1;
        @(posedge clk); #1;
        drv_valid = 1'b0;
    endtask

    task automatic send_str(input int s, input string str);
        for (int i = 0; i < str.len(); i++) send(s, str[i]);
    endtask

    // End a load: "G", plus the checksum digits when that option is built in
    task automatic finish_load(input int s, input logic [7:0] sum);
        send(s, 8'h47);
`ifdef PROG_LOADER_CHKSUM_EN
        send(s, hexc(sum[7:4]));
        send(s, hexc(sum[3:0]));
`else
        if (sum[0] === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int    start;
        string burst;

        rst_n = 1'b0; drv_valid = 1'b0; sel = 0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_din",  {24'h0, din_a},  32'h0);
        check("reset_addr", {24'h0, addr_a}, 32'h0);
        check("reset_we",   {31'h0, we_a},   32'h0);
        check("reset_hold", {31'h0, hold_a}, 32'h0);
        check("reset_done", {31'h0, done_a}, 32'h0);
        check("reset_err",  {31'h0, err_a},  32'h0);
        check("reset_cnt",  {23'h0, cnt_a},  32'h0);
        rst_n = 1'b1;

        // Basic load
        push_wa(8'd0, 8'h0A); push_wa(8'd1, 8'hFF); eq_a.push_back(EV_DONE);
        send_str(0, "L 0A FF ");
        check("basic_hold_during", {31'h0, hold_a}, 32'h1);
        finish_load(0, 8'h09);
        settle();
        check("basic_cnt",  {23'h0, cnt_a},  32'd2);
        check("basic_hold", {31'h0, hold_a}, 32'h0);
        check("basic_err",  {31'h0, err_a},  32'h0);

        // Bad character in low nibble, then recovery
        eq_a.push_back(EV_ERR);
        send_str(0, "L 1Z");
        settle();
        check("errchar_err",  {31'h0, err_a},  32'h1);
        check("errchar_hold", {31'h0, hold_a}, 32'h0);
        check("errchar_cnt",  {23'h0, cnt_a},  32'h0);
        push_wa(8'd0, 8'h33); eq_a.push_back(EV_DONE);
        send_str(0, "L 33 ");
        finish_load(0, 8'h33);
        settle();
        check("recover_err", {31'h0, err_a}, 32'h0);
        check("recover_cnt", {23'h0, cnt_a}, 32'd1);

        // Whitespace between nibbles is an error
        eq_a.push_back(EV_ERR);
        send_str(0, "L 1 ");
        settle();
        check("space_lo_err", {31'h0, err_a}, 32'h1);

        // Empty load
        eq_a.push_back(EV_DONE);
        send_str(0, "L");
        finish_load(0, 8'h00);
        settle();
        check("empty_cnt", {23'h0, cnt_a}, 32'h0);
        check("empty_err", {31'h0, err_a}, 32'h0);

        // Restart mid-load
        push_wa(8'd0, 8'h11); push_wa(8'd1, 8'h22); push_wa(8'd0, 8'h33);
        eq_a.push_back(EV_DONE);
        send_str(0, "L 11 22 L 33 ");
        finish_load(0, 8'h33);
        settle();
        check("restart_cnt",  {23'h0, cnt_a},  32'd1);
        check("restart_addr", {24'h0, addr_a}, 32'd1);

        // Full memory on the 4-byte instance
        push_wb(2'd0, 8'h01); push_wb(2'd1, 8'h02); push_wb(2'd2, 8'h03); push_wb(2'd3, 8'h04);
        eq_b.push_back(EV_ERR);
        send_str(1, "L0102030405");
        settle();
        check("ovf_err",  {31'h0, err_b},  32'h1);
        check("ovf_cnt",  {29'h0, cnt_b},  32'd4);
        check("ovf_hold", {31'h0, hold_b}, 32'h0);
        check("ovf_addr", {30'h0, addr_b}, 32'd3);

        // Back-to-back characters
`ifdef PROG_LOADER_CHKSUM_EN
        burst = "L12G12";
`else
        burst = "L12G";
`endif
        push_wa(8'd0, 8'h12); eq_a.push_back(EV_DONE);
        @(posedge clk); #1;
        sel = 0; start = cyc;
        for (int i = 0; i < burst.len(); i++) begin
            rx_data = burst[i]; drv_valid = 1'b1;
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        settle();
        check("tput_we_cycle", last_we_cyc - start, 32'd3);
        check("tput_done_cycle", last_done_cyc - start, 32'(burst.len()));

`ifdef PROG_LOADER_CHKSUM_EN
        push_wa(8'd0, 8'h10); push_wa(8'd1, 8'h20); eq_a.push_back(EV_DONE);
        send_str(0, "L 10 20 G30");
        settle();
        check("chk_ok_err", {31'h0, err_a}, 32'h0);
        push_wa(8'd0, 8'h10); push_wa(8'd1, 8'h20); eq_a.push_back(EV_ERR);
        send_str(0, "L 10 20 G31");
        settle();
        check("chk_bad_err", {31'h0, err_a}, 32'h1);
`endif

        // Reset between the two nibbles of a byte
        send_str(0, "L5");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_din",  {24'h0, din_a},  32'h0);
        check("rst_addr", {24'h0, addr_a}, 32'h0);
        check("rst_we",   {31'h0, we_a},   32'h0);
        check("rst_hold", {31'h0, hold_a}, 32'h0);
        check("rst_done", {31'h0, done_a}, 32'h0);
        check("rst_err",  {31'h0, err_a},  32'h0);
        check("rst_cnt",  {23'h0, cnt_a},  32'h0);
        rst_n = 1'b1;
        send(0, 8'h35);
        settle();
        check("post_rst_hold", {31'h0, hold_a}, 32'h0);
        check("post_rst_cnt",  {23'h0, cnt_a},  32'h0);

        check("wq_a_empty", wq_a.size(), 32'h0);
        check("wq_b_empty", wq_b.size(), 32'h0);
        check("eq_a_empty", eq_a.size(), 32'h0);
        check("eq_b_empty", eq_b.size(), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
